// File: rtl/guess_round_ctrl.sv
// Round sequencer for the guess-number game. Samples buttons on the prescaler
// tick, routes symbols into the secret or guess buffer, runs the compare
// handshake with the match datapath, counts turns and raises win/lose.
module guess_round_ctrl #(
    parameter int MIN_SYMS  = 4,
    parameter int MAX_SYMS  = 7,
    parameter int MAX_TURNS = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] btn,
    input  logic       enter,
    output logic       sym_we,
    output logic       sym_sel,
    output logic [2:0] sym_pos,
    output logic [1:0] sym_code,
    output logic       clr_secret,
    output logic       clr_guess,
    output logic       cmp_req,
    input  logic       cmp_ack,
    input  logic       cmp_match,
    output logic [2:0] secret_len,
    output logic [2:0] guess_len,
    output logic [1:0] len_rel,
    output logic [2:0] turn,
    output logic [2:0] state,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        SECRET  = 3'd0,
        GUESS   = 3'd1,
        COMPARE = 3'd2,
        RESULT  = 3'd3,
        WIN     = 3'd4,
        LOSE    = 3'd5
    } state_t;

    localparam logic [2:0] MIN_L   = 3'(MIN_SYMS);
    localparam logic [2:0] MAX_L   = 3'(MAX_SYMS);
    localparam logic [2:0] TURNS_L = 3'(MAX_TURNS);

    // Saturating increment: counters stop at their limit instead of wrapping.
    function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
        return (v >= lim) ? lim : v + 3'd1;
    endfunction

    // Lowest-index pressed button wins; the others are dropped for this tick.
    function automatic logic [1:0] first_press(input logic [3:0] p);
        if (p[0])      return 2'd0;
        else if (p[1]) return 2'd1;
        else if (p[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Length relation reported after a compare: 00 equal, 01 shorter, 10 longer.
    function automatic logic [1:0] len_compare(input logic [2:0] g, input logic [2:0] s);
        if (g == s)     return 2'b00;
        else if (g < s) return 2'b01;
        else            return 2'b10;
    endfunction

    state_t     state_r, state_nxt;
    logic [3:0] btn_hist;
    logic       enter_hist;
    logic [3:0] press;
    logic       enter_p;
    logic [2:0] turn_inc;

    logic       sym_we_nxt, sym_sel_nxt, clr_secret_nxt, clr_guess_nxt;
    logic [2:0] sym_pos_nxt, secret_len_nxt, guess_len_nxt, turn_nxt;
    logic [1:0] sym_code_nxt, len_rel_nxt;
    logic       cmp_req_nxt, win_nxt, lose_nxt;

    assign state    = state_r;
    assign turn_inc = sat_inc(turn, TURNS_L);

    // Edge detection and next-state / next-output decode; inputs act only on tick.
    always_comb begin
        press          = tick ? (btn & ~btn_hist) : 4'b0000;
        enter_p        = tick & enter & ~enter_hist;
        state_nxt      = state_r;
        sym_we_nxt     = 1'b0;
        clr_secret_nxt = 1'b0;
        clr_guess_nxt  = 1'b0;
        sym_sel_nxt    = sym_sel;
        sym_pos_nxt    = sym_pos;
        sym_code_nxt   = sym_code;
        secret_len_nxt = secret_len;
        guess_len_nxt  = guess_len;
        turn_nxt       = turn;
        len_rel_nxt    = len_rel;
        cmp_req_nxt    = cmp_req;
        win_nxt        = win;
        lose_nxt       = lose;

        case (state_r)
            SECRET: begin
                if (enter_p) begin
                    if (secret_len >= MIN_L) begin
                        state_nxt     = GUESS;
                        clr_guess_nxt = 1'b1;
                        guess_len_nxt = 3'd0;
                    end else begin
                        clr_secret_nxt = 1'b1;
                        secret_len_nxt = 3'd0;
                    end
                end else if (press != 4'b0000 && secret_len < MAX_L) begin
                    sym_we_nxt     = 1'b1;
                    sym_sel_nxt    = 1'b0;
                    sym_pos_nxt    = secret_len;
                    sym_code_nxt   = first_press(press);
                    secret_len_nxt = sat_inc(secret_len, MAX_L);
                end
            end

            GUESS: begin
                if (enter_p) begin
                    if (guess_len >= MIN_L) begin
                        state_nxt   = COMPARE;
                        cmp_req_nxt = 1'b1;
                    end else begin
                        clr_guess_nxt = 1'b1;
                        guess_len_nxt = 3'd0;
                    end
                end else if (press != 4'b0000 && guess_len < MAX_L) begin
                    sym_we_nxt    = 1'b1;
                    sym_sel_nxt   = 1'b1;
                    sym_pos_nxt   = guess_len;
                    sym_code_nxt  = first_press(press);
                    guess_len_nxt = sat_inc(guess_len, MAX_L);
                end
            end

            // Request is held until the datapath acknowledges; buttons are ignored.
            COMPARE: begin
                if (cmp_ack) begin
                    cmp_req_nxt = 1'b0;
                    len_rel_nxt = len_compare(guess_len, secret_len);
                    turn_nxt    = turn_inc;
                    if (cmp_match) begin
                        state_nxt = WIN;
                        win_nxt   = 1'b1;
                    end else if (turn_inc >= TURNS_L) begin
                        state_nxt = LOSE;
                        lose_nxt  = 1'b1;
                    end else begin
                        state_nxt = RESULT;
                    end
                end
            end

            RESULT: begin
                if (enter_p) begin
                    state_nxt     = GUESS;
                    clr_guess_nxt = 1'b1;
                    guess_len_nxt = 3'd0;
                end
            end

            WIN, LOSE: begin
                state_nxt = state_r;
            end

            default: begin
                state_nxt = SECRET;
            end
        endcase
    end

    // State, edge history and registered outputs; reset clears everything.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_r    <= SECRET;
            btn_hist   <= 4'b0000;
            enter_hist <= 1'b0;
            sym_we     <= 1'b0;
            sym_sel    <= 1'b0;
            sym_pos    <= 3'd0;
            sym_code   <= 2'd0;
            clr_secret <= 1'b0;
            clr_guess  <= 1'b0;
            cmp_req    <= 1'b0;
            secret_len <= 3'd0;
            guess_len  <= 3'd0;
            len_rel    <= 2'b00;
            turn       <= 3'd0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            if (tick) begin
                btn_hist   <= btn;
                enter_hist <= enter;
            end
            state_r    <= state_nxt;
            sym_we     <= sym_we_nxt;
            sym_sel    <= sym_sel_nxt;
            sym_pos    <= sym_pos_nxt;
            sym_code   <= sym_code_nxt;
            clr_secret <= clr_secret_nxt;
            clr_guess  <= clr_guess_nxt;
            cmp_req    <= cmp_req_nxt;
            secret_len <= secret_len_nxt;
            guess_len  <= guess_len_nxt;
            len_rel    <= len_rel_nxt;
            turn       <= turn_nxt;
            win        <= win_nxt;
            lose       <= lose_nxt;
        end
    end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Testbench for guess_round_ctrl: scoreboard of expected buffer strobes plus
// per-scenario checks of state, lengths, turn count and result flags.
module tb_guess_round_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       enter = 1'b0;
    logic       cmp_ack = 1'b0;
    logic       cmp_match = 1'b0;
    logic       sym_we, sym_sel, clr_secret, clr_guess, cmp_req, win, lose;
    logic [2:0] sym_pos, secret_len, guess_len, turn, state;
    logic [1:0] sym_code, len_rel;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0] kind;  // 1 write, 2 clr_secret, 3 clr_guess
        logic       sel;
        logic [2:0] pos;
        logic [1:0] code;
    } ev_t;

    ev_t exp_q[$];

    // Reference model of the round
    logic [2:0] m_state, m_slen, m_glen, m_turn;
    logic [1:0] m_rel;
    logic [3:0] m_bh;
    logic       m_eh;

    guess_round_ctrl #(.MIN_SYMS(4), .MAX_SYMS(7), .MAX_TURNS(4)) dut (
        .CLK(CLK), .reset(reset), .tick(tick), .btn(btn), .enter(enter),
        .sym_we(sym_we), .sym_sel(sym_sel), .sym_pos(sym_pos), .sym_code(sym_code),
        .clr_secret(clr_secret), .clr_guess(clr_guess),
        .cmp_req(cmp_req), .cmp_ack(cmp_ack), .cmp_match(cmp_match),
        .secret_len(secret_len), .guess_len(guess_len), .len_rel(len_rel),
        .turn(turn), .state(state), .win(win), .lose(lose)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish within time limit");
        $fatal(1);
    end

    function automatic void push_ev(input logic [1:0] k, input logic s,
                                    input logic [2:0] p, input logic [1:0] c);
        exp_q.push_back({k, s, p, c});
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) if (p[i]) r = 2'(i);
        return r;
    endfunction

    // Strobe monitor: every strobe must match the head of the expectation queue
    always @(posedge CLK) begin : mon
        int   n;
        ev_t  obs;
        ev_t  want;
        #2;
        n = $countones({sym_we, clr_secret, clr_guess});
        if (n > 1) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_overlap: got we/cs/cg=%b%b%b, required at most one",
                     sym_we, clr_secret, clr_guess);
        end else if (n == 1) begin
            obs = sym_we ? {2'd1, sym_sel, sym_pos, sym_code}
                         : {(clr_secret ? 2'd2 : 2'd3), 1'b0, 3'd0, 2'd0};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got kind/sel/pos/code=%h, required none", obs);
            end else begin
                want = exp_q.pop_front();
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL strobe: got kind/sel/pos/code=%h, required %h", obs, want);
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge CLK);
        reset = 1'b0; tick = 1'b0; btn = 4'b0000; enter = 1'b0;
        cmp_ack = 1'b0; cmp_match = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        m_state = 3'd0; m_slen = 3'd0; m_glen = 3'd0; m_turn = 3'd0;
        m_rel = 2'b00; m_bh = 4'b0000; m_eh = 1'b0;
        exp_q.delete();
    endtask

    // Drive one tick with the given button/enter levels, predicting its effect
    task automatic apply_tick(input logic [3:0] b, input logic e);
        logic [3:0] p;
        logic       ep;
        p  = b & ~m_bh;
        ep = e & ~m_eh;
        m_bh = b;
        m_eh = e;
        case (m_state)
            3'd0: begin
                if (ep) begin
                    if (m_slen >= 3'd4) begin
                        push_ev(2'd3, 1'b0, 3'd0, 2'd0); m_state = 3'd1; m_glen = 3'd0;
                    end else begin
                        push_ev(2'd2, 1'b0, 3'd0, 2'd0); m_slen = 3'd0;
                    end
                end else if (p != 4'b0000 && m_slen < 3'd7) begin
                    push_ev(2'd1, 1'b0, m_slen, lowest(p)); m_slen++;
                end
            end
            3'd1: begin
                if (ep) begin
                    if (m_glen >= 3'd4) m_state = 3'd2;
                    else begin
                        push_ev(2'd3, 1'b0, 3'd0, 2'd0); m_glen = 3'd0;
                    end
                end else if (p != 4'b0000 && m_glen < 3'd7) begin
                    push_ev(2'd1, 1'b1, m_glen, lowest(p)); m_glen++;
                end
            end
            3'd3: begin
                if (ep) begin
                    push_ev(2'd3, 1'b0, 3'd0, 2'd0); m_glen = 3'd0; m_state = 3'd1;
                end
            end
            default: ;
        endcase
        @(negedge CLK);
        btn = b; enter = e; tick = 1'b1;
        @(negedge CLK);
        tick = 1'b0;
    endtask

    task automatic press_sym(input int i);
        apply_tick(4'b0001 << i, 1'b0);
        apply_tick(4'b0000, 1'b0);
    endtask

    task automatic submit();
        apply_tick(4'b0000, 1'b1);
        apply_tick(4'b0000, 1'b0);
    endtask

    // Answer a pending compare request after 'delay' cycles
    task automatic run_ack(input int delay, input logic match, output int hi, output bit timed_out);
        int i;
        i = 0;
        while (cmp_req !== 1'b1 && i < 10) begin
            @(negedge CLK);
            i++;
        end
        timed_out = (cmp_req !== 1'b1);
        hi = 0;
        for (int k = 0; k < delay; k++) begin
            if (cmp_req === 1'b1) hi++;
            @(negedge CLK);
        end
        cmp_ack = 1'b1; cmp_match = match;
        @(negedge CLK);
        cmp_ack = 1'b0; cmp_match = 1'b0;
        if (m_state == 3'd2) begin
            if (m_turn < 3'd4) m_turn++;
            m_rel   = (m_glen == m_slen) ? 2'b00 : (m_glen < m_slen) ? 2'b01 : 2'b10;
            m_state = match ? 3'd4 : (m_turn >= 3'd4 ? 3'd5 : 3'd3);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({state, cmp_req, secret_len, guess_len, turn, win, lose, len_rel,
             sym_we, clr_secret, clr_guess, sym_sel, sym_pos, sym_code} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got state=%0d req=%b slen=%0d glen=%0d turn=%0d win=%b lose=%b, required all 0",
                     state, cmp_req, secret_len, guess_len, turn, win, lose);
        end
    endtask

    task automatic test_secret_entry();
        apply_reset();
        for (int i = 0; i < 3; i++) press_sym(i);
        submit();
        vectors++;
        if (state !== 3'd0 || secret_len !== 3'd0) begin
            miscompares++;
            $display("FAIL short_secret: got state=%0d slen=%0d, required state=0 slen=0", state, secret_len);
        end
        for (int i = 0; i < 4; i++) press_sym(i);
        vectors++;
        if (secret_len !== 3'd4) begin
            miscompares++;
            $display("FAIL secret_len: got %0d, required 4", secret_len);
        end
        submit();
        vectors++;
        if (state !== 3'd1 || guess_len !== 3'd0) begin
            miscompares++;
            $display("FAIL to_guess: got state=%0d glen=%0d, required state=1 glen=0", state, guess_len);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL t2_pending: got %0d strobes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 8; i++) press_sym(i % 4);
        vectors++;
        if (secret_len !== 3'd7 || state !== 3'd0) begin
            miscompares++;
            $display("FAIL secret_sat: got slen=%0d state=%0d, required slen=7 state=0", secret_len, state);
        end
        submit();
        apply_tick(4'b0110, 1'b0);
        apply_tick(4'b0000, 1'b0);
        apply_tick(4'b0001, 1'b0);
        apply_tick(4'b0001, 1'b0);
        apply_tick(4'b0000, 1'b0);
        vectors++;
        if (guess_len !== 3'd2) begin
            miscompares++;
            $display("FAIL multi_held: got glen=%0d, required 2", guess_len);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL t3_pending: got %0d strobes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_win();
        int hi;
        bit to;
        apply_reset();
        for (int i = 0; i < 4; i++) press_sym(i);
        submit();
        for (int i = 0; i < 4; i++) press_sym(i);
        submit();
        vectors++;
        if (state !== 3'd2 || cmp_req !== 1'b1) begin
            miscompares++;
            $display("FAIL compare_entry: got state=%0d req=%b, required state=2 req=1", state, cmp_req);
        end
        run_ack(3, 1'b1, hi, to);
        vectors++;
        if (to || hi != 3) begin
            miscompares++;
            $display("FAIL req_hold: got timeout=%0d high_cycles=%0d, required timeout=0 high_cycles=3", to, hi);
        end
        vectors++;
        if (cmp_req !== 1'b0 || turn !== 3'd1 || len_rel !== 2'b00) begin
            miscompares++;
            $display("FAIL win_ack: got req=%b turn=%0d rel=%b, required req=0 turn=1 rel=00", cmp_req, turn, len_rel);
        end
        vectors++;
        if (win !== 1'b1 || lose !== 1'b0 || state !== 3'd4) begin
            miscompares++;
            $display("FAIL win_flag: got win=%b lose=%b state=%0d, required win=1 lose=0 state=4", win, lose, state);
        end
    endtask

    task automatic test_lose();
        int hi;
        bit to;
        apply_reset();
        for (int i = 0; i < 4; i++) press_sym(i);
        submit();
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                submit();
                vectors++;
                if (state !== 3'd1 || guess_len !== 3'd0) begin
                    miscompares++;
                    $display("FAIL reguess_%0d: got state=%0d glen=%0d, required state=1 glen=0", g, state, guess_len);
                end
            end
            for (int k = 0; k < 5; k++) press_sym((g + k) % 4);
            submit();
            run_ack(1, 1'b0, hi, to);
            vectors++;
            if (to || len_rel !== 2'b10 || turn !== 3'(g + 1) || state !== (g < 3 ? 3'd3 : 3'd5)) begin
                miscompares++;
                $display("FAIL guess_%0d: got timeout=%0d rel=%b turn=%0d state=%0d, required timeout=0 rel=10 turn=%0d state=%0d",
                         g, to, len_rel, turn, state, g + 1, (g < 3 ? 3 : 5));
            end
        end
        vectors++;
        if (lose !== 1'b1 || win !== 1'b0) begin
            miscompares++;
            $display("FAIL lose_flag: got lose=%b win=%b, required lose=1 win=0", lose, win);
        end
        apply_tick(4'b1111, 1'b1);
        apply_tick(4'b0000, 1'b0);
        press_sym(0);
        vectors++;
        if (state !== 3'd5 || turn !== 3'd4 || lose !== 1'b1 || win !== 1'b0 ||
            secret_len !== 3'd4 || guess_len !== 3'd5) begin
            miscompares++;
            $display("FAIL lose_sticky: got state=%0d turn=%0d lose=%b win=%b slen=%0d glen=%0d, required 5 4 1 0 4 5",
                     state, turn, lose, win, secret_len, guess_len);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL t5_pending: got %0d strobes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_enter_priority();
        apply_reset();
        for (int i = 0; i < 4; i++) press_sym(i);
        submit();
        for (int i = 0; i < 4; i++) press_sym(i);
        apply_tick(4'b0100, 1'b1);
        vectors++;
        if (state !== 3'd2 || cmp_req !== 1'b1 || guess_len !== 3'd4) begin
            miscompares++;
            $display("FAIL enter_priority: got state=%0d req=%b glen=%0d, required state=2 req=1 glen=4",
                     state, cmp_req, guess_len);
        end
        apply_tick(4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid_compare();
        vectors++;
        if (state !== 3'd2 || cmp_req !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got state=%0d req=%b, required state=2 req=1", state, cmp_req);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL t6_pending: got %0d strobes missing, required 0", exp_q.size());
        end
        apply_reset();
        vectors++;
        if ({state, cmp_req, secret_len, guess_len, turn, win, lose, len_rel} !== 17'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got state=%0d req=%b slen=%0d glen=%0d turn=%0d win=%b lose=%b rel=%b, required all 0",
                     state, cmp_req, secret_len, guess_len, turn, win, lose, len_rel);
        end
        press_sym(3);
        vectors++;
        if (secret_len !== 3'd1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_write: got slen=%0d pending=%0d, required slen=1 pending=0", secret_len, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_secret_entry();
        test_saturation();
        test_win();
        test_lose();
        test_enter_priority();
        test_reset_mid_compare();
        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
